branch_history_table: RTL

- 2-bit saturating-counter branch history table.
- Supplies the decode-stage prediction bit brbitD to the pipelined controller, and is trained with the branch outcome resolved in decode (branchD, equalD).
- Indexed by fetch PC. The lookup is registered into decode alongside the instruction, and the decode-stage index is retained for the update.
- Also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_history_table.sv | 92 +++++++++
 1 files changed

// File: rtl/branch_history_table.sv
// Branch history table of 2-bit saturating counters, indexed by fetch PC.
// The fetch-stage lookup is registered into decode together with its index,
// and the decode-stage branch outcome trains the entry that was looked up.
// Saturating branch and mispredict statistics are kept alongside.
module branch_history_table #(
  parameter int         INDEX_BITS   = 6,
  parameter logic [1:0] COUNTER_INIT = 2'b01,
  parameter int         STAT_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pcF,
  input  logic                  stallD,
  input  logic                  flushD,
  input  logic                  branchD,
  input  logic                  equalD,
  output logic                  brbitD,
  output logic [INDEX_BITS-1:0] idxD,
  output logic [STAT_BITS-1:0]  branch_count,
  output logic [STAT_BITS-1:0]  mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht_q [ENTRIES];
  logic [INDEX_BITS-1:0] idx_f;
  logic                  train;
  logic [1:0]            cur_ctr;
  logic [1:0]            next_ctr;
  logic [1:0]            eff_ctr;
  logic                  pred_f;
  logic                  unused_pc;

  // Word-aligned PC: the low two bits and the bits above the index never
  // select an entry, so aliasing PCs share one counter.
  assign idx_f     = pcF[INDEX_BITS+1:2];
  assign unused_pc = ^{pcF[31:INDEX_BITS+2], pcF[1:0]};

  // Training strength and next counter value, plus the write-to-read bypass
  // so a fetch of the entry being trained sees the updated counter.
  always_comb begin
    train    = branchD & ~stallD & ~flushD;
    cur_ctr  = bht_q[idxD];
    next_ctr = cur_ctr;
    if (equalD) begin
      if (cur_ctr != 2'd3) next_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'd0) next_ctr = cur_ctr - 2'd1;
    end
    eff_ctr = bht_q[idx_f];
    if (train && (idx_f == idxD)) eff_ctr = next_ctr;
    pred_f = eff_ctr[1];
  end

  // Counter table: reset to the weak initial state, otherwise train the
  // entry of the branch currently in decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= COUNTER_INIT;
    end else if (train) begin
      bht_q[idxD] <= next_ctr;
    end
  end

  // Decode-stage prediction register: flush clears, stall holds, else load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      brbitD <= 1'b0;
      idxD   <= '0;
    end else if (flushD) begin
      brbitD <= 1'b0;
      idxD   <= '0;
    end else if (!stallD) begin
      brbitD <= pred_f;
      idxD   <= idx_f;
    end
  end

  // Statistics: count trained branches and those whose registered prediction
  // disagreed with the resolved outcome, both sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      if (branch_count != '1) branch_count <= branch_count + 1'b1;
      if ((equalD != brbitD) && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule
